// File: rtl/s_axi_burst_sink.sv
// s_axi_burst_sink
//   AXI4 write-only slave that absorbs bursts from the BRAM master and stores
//   each accepted beat, byte-wise under wstrb, into an internal word array.
//   One B response is returned per burst; a registered readback port lets
//   downstream logic inspect the array.
//
// Optional feature: define SINK_STATS_EN to build the burst/error counters.
//   When undefined, burst_cnt_o and err_cnt_o are tied to zero.
//
// Ports
//   clk, areset          clock and synchronous active-high reset
//   aw*_i / awready_o    write address channel (id, addr, len, size, burst)
//   w*_i / wready_o      write data channel (id, data, strb, last)
//   bid_o, bresp_o       write response (OKAY 00 / SLVERR 10), bvalid_o/bready_i
//   rd_addr_i/rd_data_o  word readback, one cycle latency, 0 past DEPTH
//   burst_cnt_o          completed B handshakes
//   err_cnt_o            completed SLVERR handshakes

module s_axi_burst_sink #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic [3:0]                 awid_i,
  input  logic [ADDR_WIDTH-1:0]      awaddr_i,
  input  logic [7:0]                 awlen_i,
  input  logic [2:0]                 awsize_i,
  input  logic [1:0]                 awburst_i,
  input  logic                       awvalid_i,
  output logic                       awready_o,
  input  logic [3:0]                 wid_i,
  input  logic [DATA_WIDTH-1:0]      wdata_i,
  input  logic [DATA_WIDTH/8-1:0]    wstrb_i,
  input  logic                       wlast_i,
  input  logic                       wvalid_i,
  output logic                       wready_o,
  output logic [3:0]                 bid_o,
  output logic [1:0]                 bresp_o,
  output logic                       bvalid_o,
  input  logic                       bready_i,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr_i,
  output logic [DATA_WIDTH-1:0]      rd_data_o,
  output logic [15:0]                burst_cnt_o,
  output logic [15:0]                err_cnt_o
);

  localparam int         STRB_W    = DATA_WIDTH / 8;
  localparam int         SIZE_LOG  = $clog2(STRB_W);
  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [2:0] SIZE_CODE = 3'(SIZE_LOG);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [3:0]              bid_q, bid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [3:0]              awid_q, awid_d;
  logic [ADDR_WIDTH-1:0]   start_q, start_d;
  logic                    below_q, below_d;
  logic [7:0]              len_q, len_d;
  logic                    fixed_q, fixed_d;
  logic                    err_q, err_d;
  logic [8:0]              beat_q, beat_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic [ADDR_WIDTH:0]     aw_off;
  logic [ADDR_WIDTH:0]     beat_idx;
  logic                    in_range;
  logic                    late;
  logic                    err_beat;
  logic                    w_fire;
  logic                    b_fire;
  logic                    wr_en;
  logic                    rd_in_range;

  // The top bit of aw_off is the borrow, i.e. the start address lies below
  // BASE_ADDR. The beat word index is one bit wider than the address so a
  // long INCR burst near the top cannot wrap back into the array.
  assign aw_off   = {1'b0, awaddr_i} - {1'b0, BASE_ADDR};
  assign beat_idx = {1'b0, start_q} + (ADDR_WIDTH+1)'(fixed_q ? 9'd0 : beat_q);
  assign in_range = !below_q && (beat_idx < (ADDR_WIDTH+1)'(DEPTH));
  assign late     = beat_q > {1'b0, len_q};
  assign w_fire   = (state_q == DATA) && wready_q && wvalid_i;
  assign b_fire   = (state_q == RESP) && bvalid_q && bready_i;
  assign err_beat = !in_range || late || (wid_i != awid_q) ||
                    (wlast_i && (beat_q != {1'b0, len_q}));
  // A beat that lands in the reset cycle is discarded along with the burst.
  assign wr_en    = w_fire && !err_q && in_range && !late && !areset;

  generate
    if (DEPTH == (1 << IDX_W)) begin : g_rd_full
      assign rd_in_range = 1'b1;
    end else begin : g_rd_part
      assign rd_in_range = (rd_addr_i < IDX_W'(DEPTH));
    end
  endgenerate

  // Next-state logic for the IDLE -> DATA -> RESP handshake sequencer.
  // awready is re-armed whenever the FSM sits in IDLE, which also gives the
  // "ready one cycle after reset release" behaviour for free.
  always_comb begin
    state_d   = state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    awid_d    = awid_q;
    start_d   = start_q;
    below_d   = below_q;
    len_d     = len_q;
    fixed_d   = fixed_q;
    err_d     = err_q;
    beat_d    = beat_q;
    unique case (state_q)
      IDLE: begin
        awready_d = 1'b1;
        if (awvalid_i && awready_q) begin
          awready_d = 1'b0;
          wready_d  = 1'b1;
          state_d   = DATA;
          awid_d    = awid_i;
          start_d   = aw_off[ADDR_WIDTH-1:0] >> SIZE_LOG;
          below_d   = aw_off[ADDR_WIDTH];
          len_d     = awlen_i;
          fixed_d   = (awburst_i == 2'b00);
          err_d     = (awsize_i != SIZE_CODE) || awburst_i[1];
          beat_d    = '0;
        end
      end
      DATA: begin
        if (w_fire) begin
          err_d  = err_q | err_beat;
          // Saturate so an endless late burst never aliases back to beat 0.
          beat_d = (beat_q == 9'h1FF) ? beat_q : beat_q + 9'd1;
          if (wlast_i) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = awid_q;
            bresp_d  = (err_q | err_beat) ? 2'b10 : 2'b00;
            state_d  = RESP;
          end
        end
      end
      RESP: begin
        if (b_fire) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Readback mux; out-of-range words read as zero.
  always_comb begin
    rd_data_d = '0;
    if (rd_in_range) rd_data_d = mem_q[rd_addr_i];
  end

  // Control and output registers, all cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (areset) begin
      state_q   <= IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      awid_q    <= '0;
      start_q   <= '0;
      below_q   <= 1'b0;
      len_q     <= '0;
      fixed_q   <= 1'b0;
      err_q     <= 1'b0;
      beat_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      awid_q    <= awid_d;
      start_q   <= start_d;
      below_q   <= below_d;
      len_q     <= len_d;
      fixed_q   <= fixed_d;
      err_q     <= err_d;
      beat_q    <= beat_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array: never reset, written byte-wise under wstrb.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_i[b]) mem_q[beat_idx[IDX_W-1:0]][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

`ifdef SINK_STATS_EN
  logic [15:0] burst_cnt_q, burst_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Statistics count completed B handshakes; both wrap naturally at 16 bits.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (b_fire) begin
      burst_cnt_d = burst_cnt_q + 16'd1;
      if (bresp_q == 2'b10) err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      burst_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign burst_cnt_o = burst_cnt_q;
  assign err_cnt_o   = err_cnt_q;
`else
  assign burst_cnt_o = '0;
  assign err_cnt_o   = '0;
`endif

  assign awready_o = awready_q;
  assign wready_o  = wready_q;
  assign bvalid_o  = bvalid_q;
  assign bid_o     = bid_q;
  assign bresp_o   = bresp_q;
  assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_s_axi_burst_sink.sv
// tb_s_axi_burst_sink
//   Drives AXI bursts into s_axi_burst_sink and compares every response,
//   handshake level and array word against a beat-level behavioural model.

module tb_s_axi_burst_sink;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        areset;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready_o;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready_o;
  logic [3:0]  bid_o;
  logic [1:0]  bresp_o;
  logic        bvalid_o;
  logic        bready;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data_o;
  logic [15:0] burst_cnt_o;
  logic [15:0] err_cnt_o;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state: array image, which words hold known data, and
  // the expected statistics.
  logic [31:0] model_mem   [DEPTH];
  bit          model_known [DEPTH];
  logic [15:0] model_bursts;
  logic [15:0] model_errs;

  // Beat payloads for the next burst.
  logic [31:0] bdata [80];
  logic [3:0]  bstrb [80];
  logic [3:0]  bwid  [80];

  always #5 clk = ~clk;

  s_axi_burst_sink dut (
    .clk        (clk),
    .areset     (areset),
    .awid_i     (awid),
    .awaddr_i   (awaddr),
    .awlen_i    (awlen),
    .awsize_i   (awsize),
    .awburst_i  (awburst),
    .awvalid_i  (awvalid),
    .awready_o  (awready_o),
    .wid_i      (wid),
    .wdata_i    (wdata),
    .wstrb_i    (wstrb),
    .wlast_i    (wlast),
    .wvalid_i   (wvalid),
    .wready_o   (wready_o),
    .bid_o      (bid_o),
    .bresp_o    (bresp_o),
    .bvalid_o   (bvalid_o),
    .bready_i   (bready),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data_o),
    .burst_cnt_o(burst_cnt_o),
    .err_cnt_o  (err_cnt_o)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkStats();
`ifdef SINK_STATS_EN
    checkOutput("burst_cnt", burst_cnt_o, model_bursts);
    checkOutput("err_cnt", err_cnt_o, model_errs);
`else
    checkOutput("burst_cnt_tied", burst_cnt_o, 0);
    checkOutput("err_cnt_tied", err_cnt_o, 0);
`endif
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_awready"}, awready_o, 0);
    checkOutput({tag, "_wready"}, wready_o, 0);
    checkOutput({tag, "_bvalid"}, bvalid_o, 0);
    checkOutput({tag, "_bid"}, bid_o, 0);
    checkOutput({tag, "_bresp"}, bresp_o, 0);
    checkOutput({tag, "_rd_data"}, rd_data_o, 0);
  endtask

  task automatic applyReset();
    @(negedge clk);
    areset = 1'b1; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
    repeat (2) @(negedge clk);
    checkIdleOutputs("reset");
    model_bursts = '0;
    model_errs   = '0;
    checkStats();
    areset = 1'b0;
    @(negedge clk);
    checkOutput("reset_release_awready", awready_o, 1);
  endtask

  task automatic readWord(input int idx, input logic [31:0] exp, input string tag);
    @(negedge clk);
    rd_addr = 6'(idx);
    @(negedge clk);
    checkOutput(tag, rd_data_o, exp);
  endtask

  task automatic checkArray();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      rd_addr = 6'(i);
      @(negedge clk);
      if (model_known[i]) checkOutput($sformatf("array[%0d]", i), rd_data_o, model_mem[i]);
    end
  endtask

  // One complete burst: AW, nb beats (wlast on the last), then B with bready
  // held low for bdelay cycles. reset_at >= 0 pulses areset with that beat.
  task automatic applyStimulus(input logic [3:0] id, input logic [31:0] addr, input int len,
                               input logic [2:0] size, input logic [1:0] burst, input int nb,
                               input int bdelay, input bit w_early, input int reset_at);
    bit          err;
    int          word;
    int          widx;
    int          cnt;
    logic [31:0] old;
    err  = (size != 3'd2) || (burst >= 2'd2);
    word = int'(addr >> 2);
    @(negedge clk);
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst;
    if (w_early) begin
      wvalid = 1'b1; wdata = bdata[0]; wstrb = bstrb[0]; wid = bwid[0]; wlast = (nb == 1);
    end
    cnt = 0;
    while (awready_o !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
    if (cnt >= 20) begin checkOutput("aw_timeout", 0, 1); awvalid = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    checkOutput("aw_awready_low", awready_o, 0);
    checkOutput("aw_wready_high", wready_o, 1);
    for (int k = 0; k < nb; k++) begin
      if (!(k == 0 && w_early)) begin
        wvalid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        wvalid = 1'b1; wdata = bdata[k]; wstrb = bstrb[k]; wid = bwid[k]; wlast = (k == nb - 1);
      end
      widx = (burst == 2'b00) ? word : word + k;
      old  = '0;
      if (widx < DEPTH) begin rd_addr = 6'(widx); old = model_mem[widx]; end
      if (k == reset_at) areset = 1'b1;
      cnt = 0;
      while (wready_o !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
      if (cnt >= 20) begin checkOutput("w_timeout", 0, 1); wvalid = 1'b0; return; end
      @(posedge clk);
      @(negedge clk);
      if (k == reset_at) begin
        wvalid = 1'b0; wlast = 1'b0;
        checkIdleOutputs("midreset");
        model_bursts = '0;
        model_errs   = '0;
        checkStats();
        areset = 1'b0;
        @(negedge clk);
        checkOutput("midreset_awready", awready_o, 1);
        checkOutput("midreset_no_b", bvalid_o, 0);
        return;
      end
      if (widx < DEPTH && model_known[widx]) checkOutput("rd_old_on_write", rd_data_o, old);
      if (!err && k <= len && widx < DEPTH) begin
        for (int b = 0; b < 4; b++)
          if (bstrb[k][b]) model_mem[widx][b*8 +: 8] = bdata[k][b*8 +: 8];
      end
      if (widx >= DEPTH || k > len || bwid[k] != id) err = 1'b1;
      if (k == nb - 1 && nb != len + 1) err = 1'b1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    checkOutput("b_bvalid", bvalid_o, 1);
    checkOutput("b_bid", bid_o, id);
    checkOutput("b_bresp", bresp_o, err ? 2'b10 : 2'b00);
    checkOutput("b_wready_low", wready_o, 0);
    checkOutput("b_awready_low", awready_o, 0);
    for (int d = 0; d < bdelay; d++) begin
      @(negedge clk);
      checkOutput("hold_bvalid", bvalid_o, 1);
      checkOutput("hold_bid", bid_o, id);
      checkOutput("hold_bresp", bresp_o, err ? 2'b10 : 2'b00);
      checkOutput("hold_awready", awready_o, 0);
      checkOutput("hold_wready", wready_o, 0);
    end
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    model_bursts = model_bursts + 16'd1;
    if (err) model_errs = model_errs + 16'd1;
    checkOutput("post_b_bvalid", bvalid_o, 0);
    checkOutput("post_b_awready", awready_o, 1);
    checkStats();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int len, nb, r;
    areset = 1'b1; awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = '0;
    awburst = '0; wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0; rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin model_mem[i] = '0; model_known[i] = 1'b0; end
    model_bursts = '0; model_errs = '0;

    applyReset();

    // Preload every word so the model image is fully known.
    for (int k = 0; k < 64; k++) begin bdata[k] = $urandom; bstrb[k] = 4'hF; bwid[k] = 4'h1; end
    applyStimulus(4'h1, 32'h0, 63, 3'd2, 2'b01, 64, 0, 1'b0, -1);
    for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b1;
    checkArray();

    // Basic INCR burst to words 4..9.
    for (int k = 0; k < 6; k++) begin bdata[k] = 32'hA0 + k; bstrb[k] = 4'hF; bwid[k] = 4'h3; end
    applyStimulus(4'h3, 32'h10, 5, 3'd2, 2'b01, 6, 0, 1'b0, -1);
    readWord(4, 32'hA0, "t1_word4");
    readWord(9, 32'hA5, "t1_word9");

    // Partial strobe merge on word 0.
    bdata[0] = 32'hFFFF_FFFF; bstrb[0] = 4'hF; bwid[0] = 4'h2;
    applyStimulus(4'h2, 32'h0, 0, 3'd2, 2'b01, 1, 0, 1'b0, -1);
    bdata[0] = 32'h1234_5678; bstrb[0] = 4'b0011;
    applyStimulus(4'h2, 32'h0, 0, 3'd2, 2'b01, 1, 0, 1'b0, -1);
    readWord(0, 32'hFFFF_5678, "t2_word0");

    // Unsupported burst type: beats accepted, nothing written.
    bdata[0] = 32'h55; bdata[1] = 32'h66; bstrb[0] = 4'hF; bstrb[1] = 4'hF;
    bwid[0] = 4'h4; bwid[1] = 4'h4;
    applyStimulus(4'h4, 32'h20, 1, 3'd2, 2'b10, 2, 0, 1'b0, -1);

    // Burst running off the end of the array.
    for (int k = 0; k < 4; k++) begin bdata[k] = k + 1; bstrb[k] = 4'hF; bwid[k] = 4'h5; end
    applyStimulus(4'h5, 32'hF8, 3, 3'd2, 2'b01, 4, 0, 1'b0, -1);
    readWord(62, 32'h1, "t4_word62");
    readWord(63, 32'h2, "t4_word63");

    // Early wlast with W presented while still in IDLE.
    for (int k = 0; k < 2; k++) begin bdata[k] = $urandom; bstrb[k] = 4'hF; bwid[k] = 4'h6; end
    applyStimulus(4'h6, 32'h40, 3, 3'd2, 2'b01, 2, 0, 1'b1, -1);

    // bready stalled for 5 cycles.
    bdata[0] = $urandom; bstrb[0] = 4'hF; bwid[0] = 4'h7;
    applyStimulus(4'h7, 32'h80, 0, 3'd2, 2'b00, 1, 5, 1'b0, -1);
    checkArray();

    // Reset in the middle of a burst after two beats have landed.
    for (int k = 0; k < 6; k++) begin bdata[k] = 32'h0; bstrb[k] = 4'hF; bwid[k] = 4'h3; end
    applyStimulus(4'h3, 32'h10, 5, 3'd2, 2'b01, 6, 0, 1'b0, -1);
    for (int k = 0; k < 6; k++) bdata[k] = 32'hA0 + k;
    applyStimulus(4'h3, 32'h10, 5, 3'd2, 2'b01, 6, 0, 1'b0, 2);
    for (int k = 0; k < 2; k++) model_mem[4 + k] = 32'hA0 + k;
    readWord(5, 32'hA1, "midreset_word5");
    readWord(6, 32'h0, "midreset_word6");
    checkArray();

    // Randomised bursts.
    for (int t = 0; t < 25; t++) begin
      logic [3:0] id;
      logic [2:0] size;
      logic [1:0] burst;
      id  = 4'($urandom);
      len = $urandom_range(0, 7);
      nb  = len + 1;
      r   = $urandom_range(0, 9);
      if (r == 0 && len > 0) nb = len;
      if (r == 1) nb = len + 2;
      size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      r     = $urandom_range(0, 9);
      burst = (r == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      for (int k = 0; k < nb; k++) begin
        bdata[k] = $urandom;
        bstrb[k] = 4'($urandom);
        bwid[k]  = ($urandom_range(0, 15) == 0) ? ~id : id;
      end
      applyStimulus(id, 32'($urandom_range(0, 70)) << 2, len, size, burst, nb,
                    $urandom_range(0, 3), 1'($urandom), -1);
    end
    checkArray();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
